// File: rtl/sensor_conditioner.sv
// Loop-detector and emergency-input front-end: synchronise, debounce, latch calls, stretch preemption.
// Optional build macro STUCK_DETECT_EN adds stuck-loop detection with fail-safe recall.
module sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EMERG_HOLD      = 2,
  parameter int STUCK_TIME      = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic ns_sensor_raw,
  input  logic ew_sensor_raw,
  input  logic emerg_raw,
  input  logic ns_serve_ack,
  input  logic ew_serve_ack,
  output logic ns_call,
  output logic ew_call,
  output logic emergency_req,
  output logic emergency_pulse,
  output logic ns_stuck,
  output logic ew_stuck,
  output logic sensor_fault
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (EMERG_HOLD > 0) ? $clog2(EMERG_HOLD + 1) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(EMERG_HOLD);

  typedef enum logic [1:0] {E_IDLE, E_ACTIVE, E_HOLD} emerg_state_t;

  // channel index: 0 = N/S, 1 = E/W, 2 = emergency
  logic [2:0]    raw;
  logic [2:0]    sync_q [SYNC_STAGES];
  logic [2:0]    sync;
  logic [2:0]    db_q, db_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [1:0]    ack;
  logic [1:0]    call_q, call_d;
  logic [1:0]    stuck_q, stuck_d;
  logic          fault_q;

  emerg_state_t  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          req_q, pulse_q;

  assign raw  = {emerg_raw, ew_sensor_raw, ns_sensor_raw};
  assign ack  = {ew_serve_ack, ns_serve_ack};
  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      db_d[c]  = db_q[c];
      cnt_d[c] = '0;
      if (sync[c] != db_q[c]) begin
        if (cnt_q[c] == DB_LAST) db_d[c]  = sync[c];
        else                     cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Calls follow the debounced value as it updates so a detection appears on the same edge.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      call_d[c] = call_q[c];
      if (db_d[c] || stuck_q[c]) call_d[c] = 1'b1;
      else if (ack[c])           call_d[c] = 1'b0;
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_TIME + 1);
  localparam logic [SW-1:0] ST_MAX = SW'(STUCK_TIME);
  logic [SW-1:0] scnt_q [2];
  logic [SW-1:0] scnt_d [2];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      scnt_d[c] = scnt_q[c];
      if (!db_q[c])                             scnt_d[c] = '0;
      else if (tick_1hz && scnt_q[c] != ST_MAX) scnt_d[c] = scnt_q[c] + 1'b1;
      stuck_d[c] = stuck_q[c] | (scnt_d[c] == ST_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt_q[0] <= '0;
      scnt_q[1] <= '0;
    end else begin
      scnt_q[0] <= scnt_d[0];
      scnt_q[1] <= scnt_d[1];
    end
  end
`else
  assign stuck_d = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      E_IDLE:   if (db_q[2]) state_d = E_ACTIVE;
      E_ACTIVE: if (!db_q[2]) begin
        state_d = E_HOLD;
        hold_d  = HOLD_LD;
      end
      E_HOLD: begin
        if (db_q[2])              state_d = E_ACTIVE;
        else if (hold_q == '0)    state_d = E_IDLE;
        else if (tick_1hz) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) state_d = E_IDLE;
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
      db_q    <= '0;
      call_q  <= '0;
      stuck_q <= '0;
      fault_q <= 1'b0;
      state_q <= E_IDLE;
      hold_q  <= '0;
      req_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int c = 0; c < 3; c++) cnt_q[c] <= cnt_d[c];
      db_q    <= db_d;
      call_q  <= call_d;
      stuck_q <= stuck_d;
      fault_q <= |stuck_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      req_q   <= (state_d != E_IDLE);
      pulse_q <= (state_q == E_IDLE) && (state_d == E_ACTIVE);
    end
  end

  assign ns_call         = call_q[0];
  assign ew_call         = call_q[1];
  assign emergency_req   = req_q;
  assign emergency_pulse = pulse_q;
  assign ns_stuck        = stuck_q[0];
  assign ew_stuck        = stuck_q[1];
  assign sensor_fault    = fault_q;

endmodule
